// File: rtl/free_list_mp.sv
// Multi-port physical-register free list for rename: circular queue of free pregs
// with ALLOC_W allocation lanes, FREE_W return lanes and head-pointer checkpoints.
module free_list_mp #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int NUM_CKPT  = 4,
  localparam int PW  = $clog2(NUM_PREGS),
  localparam int CW  = $clog2(NUM_PREGS + 1),
  localparam int CKW = $clog2(NUM_CKPT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALLOC_W-1:0]    alloc_req,
  output logic                  alloc_ready,
  output logic [ALLOC_W*PW-1:0] alloc_preg,
  input  logic [FREE_W-1:0]     free_valid,
  input  logic [FREE_W*PW-1:0]  free_preg,
  input  logic                  ckpt_save,
  input  logic [CKW-1:0]        ckpt_id,
  input  logic                  recover,
  input  logic [CKW-1:0]        recover_id,
  output logic [CW-1:0]         free_count,
  output logic                  empty,
  output logic                  err_overflow
);

  localparam logic [CW:0]   FULL_OCC   = (CW+1)'(NUM_PREGS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_PREGS);

  logic [PW-1:0] queue     [NUM_PREGS];
  logic [PW-1:0] ckpt_head [NUM_CKPT];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          alloc_fire;
  logic [CW-1:0] n_req;
  logic [CW-1:0] n_a;
  logic [PW-1:0] head_alloc;
  logic [PW-1:0] tail_next;
  logic [CW:0]   occ;
  logic          ovf;
  logic [FREE_W-1:0] fwe;
  logic [PW-1:0] faddr [FREE_W];
  logic [PW-1:0] rec_head;
  logic [PW-1:0] rec_diff;
  logic [CW-1:0] rec_count;

  assign alloc_ready  = (count >= CW'(ALLOC_W));
  assign free_count   = count;
  assign empty        = (count == '0);

  always_comb begin
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_preg[i*PW +: PW] = queue[head + PW'(i)];
    end
  end

  always_comb begin
    n_req = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      n_req = n_req + CW'(alloc_req[i]);
    end
    alloc_fire = (alloc_req != '0) && alloc_ready && !recover;
    n_a        = alloc_fire ? n_req : '0;
    head_alloc = head + n_a[PW-1:0];
  end

  // Frees are accepted in lane order against the occupancy left after this cycle's allocation.
  always_comb begin
    occ       = {1'b0, count - n_a};
    tail_next = tail;
    ovf       = 1'b0;
    fwe       = '0;
    for (int i = 0; i < FREE_W; i++) begin
      faddr[i] = '0;
      if (free_valid[i] && (free_preg[i*PW +: PW] != '0)) begin
        if (occ < FULL_OCC) begin
          fwe[i]    = 1'b1;
          faddr[i]  = tail_next;
          tail_next = tail_next + PW'(1);
          occ       = occ + (CW+1)'(1);
        end else begin
          ovf = 1'b1;
        end
      end
    end
  end

  // Equal pointers after a recover mean full only if the list was already full.
  always_comb begin
    rec_head  = ckpt_head[recover_id];
    rec_diff  = tail_next - rec_head;
    rec_count = ((rec_diff == '0) && (count == FULL_COUNT)) ? FULL_COUNT : CW'(rec_diff);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        queue[i] <= (i < NUM_PREGS - NUM_AREGS) ? PW'(NUM_AREGS + i) : '0;
      end
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt_head[c] <= '0;
      end
      head         <= '0;
      tail         <= PW'(NUM_PREGS - NUM_AREGS);
      count        <= CW'(NUM_PREGS - NUM_AREGS);
      err_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < FREE_W; i++) begin
        if (fwe[i]) queue[faddr[i]] <= free_preg[i*PW +: PW];
      end
      tail <= tail_next;
      if (ovf) err_overflow <= 1'b1;
      if (recover) begin
        head  <= rec_head;
        count <= rec_count;
      end else begin
        head  <= head_alloc;
        count <= occ[CW-1:0];
        if (ckpt_save) ckpt_head[ckpt_id] <= head_alloc;
      end
    end
  end

endmodule
